// File: rtl/full_calc_pkg.sv
// Shared encodings for the full calculator control unit: FSM state codes,
// multi-cycle opcodes and write-data mux selects.
package full_calc_pkg;

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] LOAD_A   = 4'd1;
    localparam logic [3:0] LOAD_B   = 4'd2;
    localparam logic [3:0] DECODE   = 4'd3;
    localparam logic [3:0] EXEC_ALU = 4'd4;
    localparam logic [3:0] MC_START = 4'd5;
    localparam logic [3:0] MC_WAIT  = 4'd6;
    localparam logic [3:0] WB_MC    = 4'd7;
    localparam logic [3:0] DONE     = 4'd8;
    localparam logic [3:0] ERR      = 4'd9;

    localparam int unsigned OP_MUL = 4;
    localparam int unsigned OP_DIV = 5;
    localparam int unsigned OP_MOD = 6;

    localparam logic [1:0] S1_ALU = 2'd0;
    localparam logic [1:0] S1_MC  = 2'd1;
    localparam logic [1:0] S1_INB = 2'd2;
    localparam logic [1:0] S1_INA = 2'd3;

endpackage

// File: rtl/full_calc_cu_if.sv
// Request/status and datapath-control bundle between the calculator control unit
// and its surroundings (register file, ALU, multi-cycle unit, requester).
interface full_calc_cu_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned OP_W   = 3
);
    logic              Go;
    logic              Acc;
    logic [OP_W-1:0]   Op;
    logic              mc_done;
    logic              mc_err;
    logic [3:0]        CS;
    logic              Done;
    logic              Err;
    logic [1:0]        s1;
    logic [ADDR_W-1:0] wa;
    logic              we;
    logic [ADDR_W-1:0] raa;
    logic              rea;
    logic [ADDR_W-1:0] rab;
    logic              reb;
    logic [1:0]        c;
    logic              s2;
    logic              mc_start;
    logic [1:0]        mc_op;

    modport master (
        output Go, Acc, Op, mc_done, mc_err,
        input  CS, Done, Err, s1, wa, we, raa, rea, rab, reb, c, s2, mc_start, mc_op
    );

    modport slave (
        input  Go, Acc, Op, mc_done, mc_err,
        output CS, Done, Err, s1, wa, we, raa, rea, rab, reb, c, s2, mc_start, mc_op
    );
endinterface

// File: rtl/full_calc_timeout.sv
// Clear/enable cycle counter that flags expiry once TIMEOUT cycles have been counted.
module full_calc_timeout #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is seen during the TIMEOUT-th enabled cycle, so the owner leaves on that edge.
    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/full_calc_cu.sv
// Calculator control unit: sequences operand loads, single-cycle ALU ops and
// start/done multi-cycle ops, with accumulate mode, timeout and error reporting.
module full_calc_cu
    import full_calc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned REG_A   = 1,
    parameter int unsigned REG_B   = 2,
    parameter int unsigned REG_R   = 3,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           CLK,
    input  logic           RST_N,
    full_calc_cu_if.slave  bus
);
    logic [3:0]      cs_q, cs_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            acc_q, acc_d;
    logic            tmr_expired;

    full_calc_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .clr_i     (cs_q == MC_START),
        .en_i      (cs_q == MC_WAIT),
        .expired_o (tmr_expired)
    );

    always_comb begin
        cs_d  = cs_q;
        op_d  = op_q;
        acc_d = acc_q;
        case (cs_q)
            IDLE: begin
                if (bus.Go) begin
                    op_d  = bus.Op;
                    acc_d = bus.Acc;
                    cs_d  = bus.Acc ? LOAD_B : LOAD_A;
                end
            end
            LOAD_A:   cs_d = LOAD_B;
            LOAD_B:   cs_d = DECODE;
            DECODE: begin
                if (op_q < OP_W'(OP_MUL)) begin
                    cs_d = EXEC_ALU;
                end else if (op_q <= OP_W'(OP_MOD)) begin
                    cs_d = MC_START;
                end else begin
                    cs_d = ERR;
                end
            end
            EXEC_ALU: cs_d = DONE;
            MC_START: cs_d = MC_WAIT;
            MC_WAIT: begin
                // A result arriving on the expiry cycle still counts.
                if (bus.mc_done) begin
                    cs_d = bus.mc_err ? ERR : WB_MC;
                end else if (tmr_expired) begin
                    cs_d = ERR;
                end
            end
            WB_MC:    cs_d = DONE;
            DONE, ERR: begin
                if (!bus.Go) begin
                    cs_d = IDLE;
                end
            end
            default:  cs_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_q  <= IDLE;
            op_q  <= '0;
            acc_q <= 1'b0;
        end else begin
            cs_q  <= cs_d;
            op_q  <= op_d;
            acc_q <= acc_d;
        end
    end

    logic [ADDR_W-1:0] raa_op;
    logic [1:0]        mc_code;

    // In accumulate mode operand A is the previous result.
    assign raa_op  = acc_q ? ADDR_W'(REG_R) : ADDR_W'(REG_A);
    assign mc_code = 2'(op_q - OP_W'(OP_MUL));

    always_comb begin
        bus.CS       = cs_q;
        bus.Done     = 1'b0;
        bus.Err      = 1'b0;
        bus.s1       = S1_ALU;
        bus.wa       = '0;
        bus.we       = 1'b0;
        bus.raa      = '0;
        bus.rea      = 1'b0;
        bus.rab      = '0;
        bus.reb      = 1'b0;
        bus.c        = 2'd0;
        bus.s2       = 1'b0;
        bus.mc_start = 1'b0;
        bus.mc_op    = 2'd0;
        case (cs_q)
            LOAD_A: begin
                bus.s1 = S1_INA;
                bus.wa = ADDR_W'(REG_A);
                bus.we = 1'b1;
            end
            LOAD_B: begin
                bus.s1 = S1_INB;
                bus.wa = ADDR_W'(REG_B);
                bus.we = 1'b1;
            end
            EXEC_ALU: begin
                bus.s1  = S1_ALU;
                bus.wa  = ADDR_W'(REG_R);
                bus.we  = 1'b1;
                bus.raa = raa_op;
                bus.rea = 1'b1;
                bus.rab = ADDR_W'(REG_B);
                bus.reb = 1'b1;
                bus.c   = op_q[1:0];
            end
            MC_START, MC_WAIT: begin
                bus.mc_start = (cs_q == MC_START);
                bus.mc_op    = mc_code;
                bus.raa      = raa_op;
                bus.rea      = 1'b1;
                bus.rab      = ADDR_W'(REG_B);
                bus.reb      = 1'b1;
            end
            WB_MC: begin
                bus.s1 = S1_MC;
                bus.wa = ADDR_W'(REG_R);
                bus.we = 1'b1;
            end
            DONE: begin
                bus.Done = 1'b1;
                bus.s2   = 1'b1;
                bus.raa  = ADDR_W'(REG_R);
                bus.rea  = 1'b1;
            end
            ERR: begin
                bus.Done = 1'b1;
                bus.Err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_full_calc_cu.sv
// Directed bench for full_calc_cu: walks each operation class cycle by cycle and
// compares state and control outputs against hand-derived values.
module tb_full_calc_cu;
    import full_calc_pkg::*;

    logic CLK;
    logic RST_N;
    int   n_cmp;
    int   n_err;
    int   mc_start_cnt;
    int   we_cnt;
    int   base;

    full_calc_cu_if #(.ADDR_W(2), .OP_W(3)) bus ();

    full_calc_cu #(
        .ADDR_W  (2),
        .REG_A   (1),
        .REG_B   (2),
        .REG_R   (3),
        .OP_W    (3),
        .TIMEOUT (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pre-edge samples of the Moore outputs: one count per cycle the strobe is high.
    initial begin
        mc_start_cnt = 0;
        we_cnt       = 0;
    end
    always @(posedge CLK) begin
        if (bus.mc_start) mc_start_cnt <= mc_start_cnt + 1;
        if (bus.we)       we_cnt       <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, ".CS"},       32'(bus.CS),       32'(IDLE));
        check({tag, ".s1"},       32'(bus.s1),       0);
        check({tag, ".we"},       32'(bus.we),       0);
        check({tag, ".wa"},       32'(bus.wa),       0);
        check({tag, ".raa"},      32'(bus.raa),      0);
        check({tag, ".rea"},      32'(bus.rea),      0);
        check({tag, ".rab"},      32'(bus.rab),      0);
        check({tag, ".reb"},      32'(bus.reb),      0);
        check({tag, ".c"},        32'(bus.c),        0);
        check({tag, ".s2"},       32'(bus.s2),       0);
        check({tag, ".Done"},     32'(bus.Done),     0);
        check({tag, ".Err"},      32'(bus.Err),      0);
        check({tag, ".mc_start"}, 32'(bus.mc_start), 0);
        check({tag, ".mc_op"},    32'(bus.mc_op),    0);
    endtask

    task automatic start_op(input logic [2:0] op, input logic acc);
        bus.Op  = op;
        bus.Acc = acc;
        bus.Go  = 1'b1;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        RST_N        = 1'b0;
        bus.Go       = 1'b0;
        bus.Acc      = 1'b0;
        bus.Op       = '0;
        bus.mc_done  = 1'b0;
        bus.mc_err   = 1'b0;

        #3;
        check_idle_outs("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        check("idle_no_go.CS", 32'(bus.CS), 32'(IDLE));

        // ALU op 2, normal mode; Op/Acc changes after launch must be ignored.
        start_op(3'd2, 1'b0);
        step();
        bus.Op  = 3'd3;
        bus.Acc = 1'b1;
        check("alu.la.CS", 32'(bus.CS), 32'(LOAD_A));
        check("alu.la.wa", 32'(bus.wa), 1);
        check("alu.la.s1", 32'(bus.s1), 3);
        check("alu.la.we", 32'(bus.we), 1);
        step();
        check("alu.lb.CS", 32'(bus.CS), 32'(LOAD_B));
        check("alu.lb.wa", 32'(bus.wa), 2);
        check("alu.lb.s1", 32'(bus.s1), 2);
        step();
        check("alu.dec.CS", 32'(bus.CS), 32'(DECODE));
        check("alu.dec.we", 32'(bus.we), 0);
        step();
        check("alu.ex.CS",  32'(bus.CS),  32'(EXEC_ALU));
        check("alu.ex.wa",  32'(bus.wa),  3);
        check("alu.ex.s1",  32'(bus.s1),  0);
        check("alu.ex.c",   32'(bus.c),   2);
        check("alu.ex.raa", 32'(bus.raa), 1);
        check("alu.ex.rab", 32'(bus.rab), 2);
        check("alu.ex.we",  32'(bus.we),  1);
        step();
        check("alu.done.CS",   32'(bus.CS),   32'(DONE));
        check("alu.done.Done", 32'(bus.Done), 1);
        check("alu.done.s2",   32'(bus.s2),   1);
        check("alu.done.raa",  32'(bus.raa),  3);
        step();
        check("alu.hold.CS", 32'(bus.CS), 32'(DONE));
        bus.Go = 1'b0;
        step();
        check("alu.idle.CS",   32'(bus.CS),   32'(IDLE));
        check("alu.idle.Done", 32'(bus.Done), 0);

        // Accumulate, op 0: LOAD_A skipped, operand A read from the result register.
        start_op(3'd0, 1'b1);
        step();
        check("acc.lb.CS", 32'(bus.CS), 32'(LOAD_B));
        step(2);
        check("acc.ex.CS",  32'(bus.CS),  32'(EXEC_ALU));
        check("acc.ex.raa", 32'(bus.raa), 3);
        check("acc.ex.c",   32'(bus.c),   0);
        step();
        check("acc.done.Done", 32'(bus.Done), 1);
        bus.Go = 1'b0;
        step();

        // DIV, result returned on the third MC_WAIT cycle.
        base = mc_start_cnt;
        start_op(3'd5, 1'b0);
        step(4);
        check("div.st.CS",       32'(bus.CS),       32'(MC_START));
        check("div.st.mc_start", 32'(bus.mc_start), 1);
        check("div.st.mc_op",    32'(bus.mc_op),    1);
        step();
        check("div.w.CS",       32'(bus.CS),       32'(MC_WAIT));
        check("div.w.mc_start", 32'(bus.mc_start), 0);
        check("div.w.mc_op",    32'(bus.mc_op),    1);
        check("div.w.rea",      32'(bus.rea),      1);
        step(2);
        bus.mc_done = 1'b1;
        step();
        bus.mc_done = 1'b0;
        check("div.wb.CS", 32'(bus.CS), 32'(WB_MC));
        check("div.wb.s1", 32'(bus.s1), 1);
        check("div.wb.we", 32'(bus.we), 1);
        check("div.wb.wa", 32'(bus.wa), 3);
        step();
        check("div.done.Done",    32'(bus.Done),             1);
        check("div.done.Err",     32'(bus.Err),              0);
        check("div.start_pulses", 32'(mc_start_cnt - base),  1);
        bus.Go = 1'b0;
        step();

        // DIV with error returned: no write after LOAD_B.
        start_op(3'd5, 1'b0);
        step(3);
        check("dz.dec.CS", 32'(bus.CS), 32'(DECODE));
        base = we_cnt;
        step(2);
        bus.mc_done = 1'b1;
        bus.mc_err  = 1'b1;
        step();
        bus.mc_done = 1'b0;
        bus.mc_err  = 1'b0;
        check("dz.CS",   32'(bus.CS),         32'(ERR));
        check("dz.Done", 32'(bus.Done),       1);
        check("dz.Err",  32'(bus.Err),        1);
        check("dz.s2",   32'(bus.s2),         0);
        check("dz.nowe", 32'(we_cnt - base),  0);
        bus.Go = 1'b0;
        step();

        // MUL timeout: eight MC_WAIT cycles then ERR; stray mc_done in IDLE ignored.
        start_op(3'd4, 1'b0);
        step(5);
        check("to.w.mc_op", 32'(bus.mc_op), 0);
        step(7);
        check("to.w8.CS", 32'(bus.CS), 32'(MC_WAIT));
        step();
        check("to.err.CS",  32'(bus.CS),  32'(ERR));
        check("to.err.Err", 32'(bus.Err), 1);
        bus.Go = 1'b0;
        step();
        check("to.idle.CS", 32'(bus.CS), 32'(IDLE));
        bus.mc_done = 1'b1;
        step();
        bus.mc_done = 1'b0;
        check("stray.CS", 32'(bus.CS), 32'(IDLE));

        // mc_done on the expiry cycle wins over the timeout.
        start_op(3'd6, 1'b0);
        step(5);
        check("mod.w.mc_op", 32'(bus.mc_op), 2);
        step(7);
        bus.mc_done = 1'b1;
        step();
        bus.mc_done = 1'b0;
        check("race.CS", 32'(bus.CS), 32'(WB_MC));
        step();
        check("race.Err", 32'(bus.Err), 0);
        bus.Go = 1'b0;
        step();

        // Illegal opcode, with Go held through ERR.
        start_op(3'd7, 1'b0);
        step(3);
        check("ill.dec.CS", 32'(bus.CS), 32'(DECODE));
        step();
        check("ill.CS",   32'(bus.CS),   32'(ERR));
        check("ill.Done", 32'(bus.Done), 1);
        check("ill.Err",  32'(bus.Err),  1);
        step();
        check("ill.hold.CS", 32'(bus.CS), 32'(ERR));
        bus.Go = 1'b0;
        step();

        // Asynchronous reset during MC_WAIT, observed between clock edges.
        start_op(3'd4, 1'b0);
        step(6);
        check("rst.w.CS", 32'(bus.CS), 32'(MC_WAIT));
        bus.Go = 1'b0;
        #1;
        RST_N = 1'b0;
        #1;
        check_idle_outs("async_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        check("rst.after.CS", 32'(bus.CS), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
